// File: rtl/spi_byte_rx.sv
// SPI mode-0 receiver, MSB first: oversamples sclk/sdi/cs_n in the clk domain,
// assembles WIDTH-bit words and queues them in a DEPTH-entry valid/ready FIFO.
module spi_byte_rx #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk,
   input  logic             sdi,
   input  logic             cs_n,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic             frame_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(WIDTH + 1);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

   logic [2:0]       sclk_q;
   logic [1:0]       sdi_q;
   logic [2:0]       cs_q;

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic [IW-1:0]    idle_q, idle_d;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             overflow_q, overflow_d;
   logic             frame_err_q;

   logic             rise, cs_sync, cs_rise, shift_en, word_done, timeout_hit, abort;
   logic [WIDTH-1:0] push_word;
   logic             full, empty, pop, push_ok, drop;

   // Bit 2 of sclk_q/cs_q is only an edge-detect delay, not part of the synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= 3'b000;
         sdi_q  <= 2'b00;
         cs_q   <= 3'b111;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk};
         sdi_q  <= {sdi_q[0], sdi};
         cs_q   <= {cs_q[1:0], cs_n};
      end
   end

   always_comb begin
      rise        = sclk_q[1] & ~sclk_q[2];
      cs_sync     = cs_q[1];
      cs_rise     = cs_q[1] & ~cs_q[2];
      shift_en    = rise & ~cs_sync;
      word_done   = shift_en & (bitcnt_q == LAST_BIT);
      // A rise in the same cycle as the timeout restarts the idle count instead.
      timeout_hit = (idle_q == IDLE_MAX) & ~shift_en;
      abort       = (bitcnt_q != '0) & (cs_rise | timeout_hit);
      push_word   = {shreg_q[WIDTH-2:0], sdi_q[1]};
   end

   always_comb begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      idle_d   = idle_q;
      if (shift_en) begin
         shreg_d  = push_word;
         bitcnt_d = word_done ? '0 : bitcnt_q + BW'(1);
      end else if (abort) begin
         bitcnt_d = '0;
      end
      if (rise || (bitcnt_q == '0) || abort) begin
         idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         idle_q      <= '0;
         frame_err_q <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         idle_q      <= idle_d;
         frame_err_q <= abort;
      end
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
   always_comb begin
      empty      = (wr_q == rd_q);
      full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop        = ~empty & rx_ready;
      push_ok    = word_done & (~full | pop);
      drop       = word_done & full & ~pop;
      wr_d       = push_ok ? wr_q + (AW+1)'(1) : wr_q;
      rd_d       = pop ? rd_q + (AW+1)'(1) : rd_q;
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q       <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok) begin
         mem_q[wr_q[AW-1:0]] <= push_word;
      end
   end

   assign rx_data   = mem_q[rd_q[AW-1:0]];
   assign rx_valid  = ~empty;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: table of single words plus hand-written
// stream, overflow, full-with-pop, abort and mid-word reset sequences.
module tb_spi_byte_rx;

   localparam int TO = 1024;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       sdi = 1'b0;
   logic       cs_n = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       overflow;
   logic       ovf_clr = 1'b0;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] word;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   spi_byte_rx #(.WIDTH(8), .DEPTH(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs_n(cs_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // sclk low 4 cycles with sdi set, then high 4 cycles; optional one-cycle pop
   // aligned with the FIFO write of this rise.
   task automatic send_bit(input logic b, input bit pop_at_push);
      sdi = b;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (pop_at_push && i == 1) rx_ready = 1'b1;
         if (pop_at_push && i == 2) rx_ready = 1'b0;
      end
      sclk = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit pop_last);
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i], pop_last && (i == 0));
      end
   endtask

   task automatic pop_chk(input string name, input logic [7:0] exp);
      chk({name, "_valid"}, 32'(rx_valid), 32'd1);
      chk({name, "_data"}, 32'(rx_data), 32'(exp));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic count_ferr(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (frame_err) cnt++;
      end
   endtask

   initial begin
      int fe;
      vecs[0] = '{8'hA5, 8'hA5};
      vecs[1] = '{8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF};
      vecs[3] = '{8'h5A, 8'h5A};
      vecs[4] = '{8'h80, 8'h80};
      vecs[5] = '{8'h01, 8'h01};

      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single words: valid within 4 cycles of the last rise, one-cycle pop empties.
      for (int v = 0; v < 6; v++) begin
         send_word(vecs[v].word, 1'b0);
         chk($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'd1);
         chk($sformatf("vec%0d_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         chk($sformatf("vec%0d_empty", v), 32'(rx_valid), 32'd0);
      end

      // Back-to-back stream keeps order.
      send_word(8'h0C, 1'b0);
      send_word(8'h01, 1'b0);
      send_word(8'h0F, 1'b0);
      send_word(8'h01, 1'b0);
      repeat (2) @(negedge clk);
      chk("stream_ovf", 32'(overflow), 32'd0);
      pop_chk("stream0", 8'h0C);
      pop_chk("stream1", 8'h01);
      pop_chk("stream2", 8'h0F);
      pop_chk("stream3", 8'h01);
      chk("stream_empty", 32'(rx_valid), 32'd0);

      // cs_n deassert with no partial word must not raise frame_err.
      cs_n = 1'b1;
      count_ferr(8, fe);
      chk("cs_idle_ferr", 32'(fe), 32'd0);
      cs_n = 1'b0;
      repeat (4) @(negedge clk);

      // Overflow: fifth word dropped, contents unchanged, ovf_clr clears.
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      send_word(8'h33, 1'b0);
      send_word(8'h44, 1'b0);
      chk("fill_ovf", 32'(overflow), 32'd0);
      send_word(8'h55, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);
      pop_chk("ovf0", 8'h11);
      pop_chk("ovf1", 8'h22);
      pop_chk("ovf2", 8'h33);
      pop_chk("ovf3", 8'h44);
      chk("ovf_empty", 32'(rx_valid), 32'd0);

      // Full FIFO with a pop in the push cycle accepts the new word.
      send_word(8'h21, 1'b0);
      send_word(8'h22, 1'b0);
      send_word(8'h23, 1'b0);
      send_word(8'h24, 1'b0);
      send_word(8'h25, 1'b1);
      repeat (2) @(negedge clk);
      chk("fullpop_ovf", 32'(overflow), 32'd0);
      pop_chk("fullpop0", 8'h22);
      pop_chk("fullpop1", 8'h23);
      pop_chk("fullpop2", 8'h24);
      pop_chk("fullpop3", 8'h25);
      chk("fullpop_empty", 32'(rx_valid), 32'd0);

      // Abort by cs_n after 3 bits, then a clean word.
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      cs_n = 1'b1;
      count_ferr(12, fe);
      chk("cs_abort_ferr", 32'(fe), 32'd1);
      chk("cs_abort_nopush", 32'(rx_valid), 32'd0);
      cs_n = 1'b0;
      send_word(8'h3C, 1'b0);
      pop_chk("after_cs", 8'h3C);

      // Abort by idle timeout after 5 bits.
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      count_ferr(TO + 10, fe);
      chk("timeout_ferr", 32'(fe), 32'd1);
      chk("timeout_nopush", 32'(rx_valid), 32'd0);
      send_word(8'h81, 1'b0);
      pop_chk("after_to", 8'h81);

      // Reset with 2 words buffered and 4 bits shifted.
      send_word(8'h12, 1'b0);
      send_word(8'h34, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      chk("pre_rst_valid", 32'(rx_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(rx_valid), 32'd0);
      chk("midrst_data", 32'(rx_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_ferr(6, fe);
      chk("post_rst_ferr", 32'(fe), 32'd0);
      send_word(8'h96, 1'b0);
      pop_chk("after_rst", 8'h96);
      chk("after_rst_empty", 32'(rx_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_byte_rx.md
# spi_byte_rx

SPI receiver (mode 0, MSB first) that deserializes an `sclk`/`sdi` bit stream into WIDTH-bit words and buffers them in a small FIFO with a valid/ready read port. It is the receive end of the link driven by the team's SPI transmitter. It is used to loop back and check the seven-segment command stream on the bench and to accept commands from an external SPI master. All inputs are oversampled in the `clk` domain; no logic runs on `sclk`.

## Interface
- WIDTH, 8: bits per word.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TIMEOUT, 1024: `clk` cycles without an `sclk` rising edge after which a partial word is discarded; ≥4.

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- sclk  in  1  serial clock from master, asynchronous.
- sdi  in  1  serial data from master, asynchronous.
- cs_n  in  1  active-low select, asynchronous; tie 0 when the master has no select.
- rx_data  out  WIDTH  FIFO head word.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pops head when rx_valid & rx_ready.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.
- frame_err  out  1  one-cycle pulse: partial word discarded.

## Operation
- Synchronizers:
  - `sclk`, `sdi` and `cs_n` each pass through 2 flops.
  - `sclk` has a third delay flop for edge detection.
  - Rise = s2 & ~s3.
  - Reset values: `sclk` and `sdi` sync flops 0, `cs_n` sync flops 1.
- Shifting:
  - On a detected rise while the synced `cs_n` = 0: `shreg <= {shreg[WIDTH-2:0], sdi_s2}`, and `bitcnt` increments.
  - Rises while the synced `cs_n` = 1 are ignored.
- Word complete: when a rise makes `bitcnt` reach WIDTH:
  - The assembled word is written to the FIFO in the same cycle.
  - `bitcnt` returns to 0.
  - The next word starts with the next rise. Back-to-back words need no gap.
- Frame abort: `bitcnt` is cleared and `frame_err` pulses for one cycle on either event below, only if `bitcnt` ≠ 0:
  - a synced `cs_n` rising (deassertion);
  - the idle counter reaching TIMEOUT.
- Idle counter: cleared on every rise and whenever `bitcnt` = 0; saturates at TIMEOUT.
- FIFO:
  - Circular buffer with write/read pointers one bit wider than log2(DEPTH); wrap-around is natural.
  - Full = pointer MSBs differ and the low bits are equal. Empty = pointers equal.
  - `rx_data` is the registered-array read at the read pointer, valid whenever `rx_valid` = 1. Value is don't-care when empty.
- Simultaneous push and pop while full: the pop frees a slot, so the push is accepted and no overflow is raised.
- Push while full with no pop: the word is dropped, `overflow` is set, and FIFO contents are unchanged.
- Overflow flag: `ovf_clr` clears `overflow`. If a drop occurs in the same cycle as `ovf_clr`, set wins.
- A pop while empty is ignored.

## Timing
- Reset values: `rx_valid` = 0, `overflow` = 0, `frame_err` = 0, `rx_data` = 0. Pointers, `bitcnt`, `shreg` and the idle counter are all 0.
- Reset mid-word discards the partial word and all FIFO contents. No `frame_err` is raised.
- Latency: a rise is detected 2–3 `clk` cycles after the pin edge; call that cycle N.
  - For the last bit of a word, the FIFO write occurs at the end of N.
  - When the FIFO was empty, `rx_valid` is 1 and `rx_data` holds the word in cycle N+1.
- A pop in cycle M presents the next entry (or `rx_valid` = 0) in cycle M+1.
- Input constraint: `sclk` high and low phases must each be ≥3 `clk` periods. `sdi` must be stable from 1 cycle before until 3 cycles after each `sclk` rise.
- `frame_err` is asserted in the cycle after the abort condition is detected.

## Test plan
- Single word: `cs_n` = 0, shift 0xA5 MSB first at `sclk` = `clk`/8, `rx_ready` = 0 → `rx_valid` rises within 4 cycles of the 8th `sclk` edge with `rx_data` = 0xA5. Pulsing `rx_ready` for 1 cycle → `rx_valid` = 0 the next cycle.
- Stream and order: send 0x0C, 0x01, 0x0F, 0x01 back-to-back with no gap → all four are read in that order, `overflow` stays 0.
- Overflow: `rx_ready` = 0, send 5 words 0x11–0x55 with DEPTH = 4 → FIFO holds 0x11–0x44, `overflow` = 1. Then pulse `ovf_clr` → `overflow` = 0.
- Full with simultaneous pop: with the FIFO full, assert `rx_ready` in exactly the cycle the 5th word is pushed → the 5th word is accepted and `overflow` stays 0.
- Aborts:
  - 3 bits then `cs_n` high → one `frame_err` pulse, no word pushed; a following 0x3C is received intact.
  - 5 bits then TIMEOUT + 5 idle cycles with `cs_n` = 0 → one `frame_err` pulse.
- Reset mid-operation: assert `rst_n` = 0 with 2 words buffered and 4 bits shifted → `rx_valid` = 0 immediately. After release, a new 0x96 is received correctly.
